// File: rtl/sr_latch_arbiter.sv
// sr_latch_arbiter: round-robin arbiter and sequencer for a shared clocked
// SR flip-flop (NAND-gated SR latch with enable). Grants one requester at a
// time, then drives S/R/enable through setup, enable pulse and hold phases.
// S and R are never both high.
//
// Optional feature macro: SR_VERIFY_EN
//   defined   -> CHECK state samples latch_q after hold; mismatch sets sticky err
//   undefined -> HOLD goes straight to DONE, latch_q unused, err stays 0
//
// Parameters:
//   NREQ     number of requesters (2..8)
//   PW       latch enable pulse width in clk1 cycles (>=1)
// Ports:
//   clk1     system clock, rising edge
//   rstn     synchronous active-low reset
//   req      per-requester request level, held until done
//   op       per-requester operation (1=set, 0=clear), sampled at grant
//   gnt      one-hot grant, high for the whole transaction
//   done     one-cycle completion pulse to the granted requester
//   latch_s  latch S input
//   latch_r  latch R input
//   latch_en latch clock/enable input
//   latch_q  latch Q feedback
//   busy     high whenever the sequencer is not idle
//   err      sticky verify-mismatch flag
module sr_latch_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = 2
) (
    input  logic            clk1,
    input  logic            rstn,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] op,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] done,
    output logic            latch_s,
    output logic            latch_r,
    output logic            latch_en,
    input  logic            latch_q,
    output logic            busy,
    output logic            err
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(PW + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
`ifdef SR_VERIFY_EN
        ST_CHECK = 3'd5,
`endif
        ST_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt;
    logic            r_op;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_done;
    logic            r_latch_s;
    logic            r_latch_r;
    logic            r_latch_en;
    logic            r_busy;
    logic            r_err;

    state_t          w_state_nxt;
    logic [IW-1:0]   w_ptr_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_op_nxt;
    logic [NREQ-1:0] w_gnt_nxt;
    logic [NREQ-1:0] w_done_nxt;
    logic            w_s_nxt;
    logic            w_r_nxt;
    logic            w_en_nxt;
    logic            w_err_nxt;

    logic            w_found;
    logic [IW-1:0]   w_winner;
    logic [IW-1:0]   w_idx;

`ifndef SR_VERIFY_EN
    // Q feedback and the registered op only matter when verifying.
    logic w_unused_bits;
    assign w_unused_bits = latch_q ^ r_op;
`endif

    // Round-robin search starting one past the last winner.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_idx    = r_ptr;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            w_idx = IW'((32'(r_ptr) + i) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = '0;
        w_s_nxt     = r_latch_s;
        w_r_nxt     = r_latch_r;
        w_en_nxt    = 1'b0;
        w_err_nxt   = r_err;

        case (r_state)
            ST_IDLE: begin
                w_s_nxt = 1'b0;
                w_r_nxt = 1'b0;
                if (w_found) begin
                    w_gnt_nxt   = NREQ'(1) << w_winner;
                    w_op_nxt    = op[w_winner];
                    w_s_nxt     = op[w_winner];
                    w_r_nxt     = ~op[w_winner];
                    w_ptr_nxt   = w_winner;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_cnt_nxt   = '0;
                w_en_nxt    = 1'b1;
                w_state_nxt = ST_PULSE;
            end
            ST_PULSE: begin
                if (r_cnt == CW'(PW - 1)) begin
                    w_en_nxt    = 1'b0;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    w_en_nxt  = 1'b1;
                end
            end
            ST_HOLD: begin
                w_s_nxt = 1'b0;
                w_r_nxt = 1'b0;
`ifdef SR_VERIFY_EN
                w_state_nxt = ST_CHECK;
`else
                w_done_nxt  = r_gnt;
                w_state_nxt = ST_DONE;
`endif
            end
`ifdef SR_VERIFY_EN
            ST_CHECK: begin
                w_s_nxt = 1'b0;
                w_r_nxt = 1'b0;
                if (latch_q != r_op) begin
                    w_err_nxt = 1'b1;
                end
                w_done_nxt  = r_gnt;
                w_state_nxt = ST_DONE;
            end
`endif
            ST_DONE: begin
                w_s_nxt     = 1'b0;
                w_r_nxt     = 1'b0;
                w_gnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_s_nxt     = 1'b0;
                w_r_nxt     = 1'b0;
                w_gnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset forces the latch controls safe.
    always_ff @(posedge clk1) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_ptr      <= IW'(NREQ - 1);
            r_cnt      <= '0;
            r_op       <= 1'b0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_latch_s  <= 1'b0;
            r_latch_r  <= 1'b0;
            r_latch_en <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_op       <= w_op_nxt;
            r_gnt      <= w_gnt_nxt;
            r_done     <= w_done_nxt;
            r_latch_s  <= w_s_nxt;
            r_latch_r  <= w_r_nxt;
            r_latch_en <= w_en_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_err      <= w_err_nxt;
        end
    end

    assign gnt      = r_gnt;
    assign done     = r_done;
    assign latch_s  = r_latch_s;
    assign latch_r  = r_latch_r;
    assign latch_en = r_latch_en;
    assign busy     = r_busy;
    assign err      = r_err;

endmodule

// File: tb/tb_sr_latch_arbiter.sv
// Scoreboard bench for sr_latch_arbiter (NREQ=4, PW=2).
module tb_sr_latch_arbiter;

    localparam int PW = 2;
`ifdef SR_VERIFY_EN
    localparam int   DLAT   = PW + 3;
    localparam int   PER    = PW + 5;
    localparam logic ERR_MM = 1'b1;
`else
    localparam int   DLAT   = PW + 2;
    localparam int   PER    = PW + 4;
    localparam logic ERR_MM = 1'b0;
`endif

    typedef struct {
        logic [3:0] v;
        logic       op;
        logic       err;
        int         cyc;
    } exp_t;

    logic       clk1;
    logic       rstn;
    logic [3:0] req;
    logic [3:0] op;
    logic [3:0] gnt;
    logic [3:0] done;
    logic       latch_s;
    logic       latch_r;
    logic       latch_en;
    logic       latch_q;
    logic       busy;
    logic       err;

    logic       q_model;
    logic       force_q0;
    int         cyc;
    int         n_cmp;
    int         n_fail;
    exp_t       gq[$];
    exp_t       dq[$];

    sr_latch_arbiter #(.NREQ(4), .PW(PW)) dut (
        .clk1     (clk1),
        .rstn     (rstn),
        .req      (req),
        .op       (op),
        .gnt      (gnt),
        .done     (done),
        .latch_s  (latch_s),
        .latch_r  (latch_r),
        .latch_en (latch_en),
        .latch_q  (latch_q),
        .busy     (busy),
        .err      (err)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk1);
            cyc++;
        end
    end

    // Behavioural SR latch: transparent while enabled.
    initial begin
        q_model = 1'b0;
        forever begin
            @(latch_en or latch_s or latch_r);
            if (latch_en === 1'b1) begin
                if (latch_s === 1'b1)      q_model = 1'b1;
                else if (latch_r === 1'b1) q_model = 1'b0;
            end
        end
    end
    assign latch_q = force_q0 ? 1'b0 : q_model;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: invariants every cycle, grant and done events against the queues.
    initial begin
        logic [3:0] prev_gnt;
        int   s_cnt;
        int   r_cnt;
        int   en_cnt;
        exp_t e;
        prev_gnt = '0;
        s_cnt    = 0;
        r_cnt    = 0;
        en_cnt   = 0;
        forever begin
            @(negedge clk1);
            check("sr_exclusive", int'(latch_s & latch_r), 0);
            if (latch_en) check("en_needs_one_of_sr", int'(latch_s ^ latch_r), 1);
            if (prev_gnt == 4'b0 && gnt != 4'b0) begin
                s_cnt  = 0;
                r_cnt  = 0;
                en_cnt = 0;
                if (gq.size() == 0) begin
                    check("gnt_unexpected", int'(gnt), 0);
                end else begin
                    e = gq.pop_front();
                    check("gnt_value", int'(gnt), int'(e.v));
                    check("gnt_cycle", cyc, e.cyc);
                end
            end
            if (gnt != 4'b0) begin
                s_cnt  += int'(latch_s);
                r_cnt  += int'(latch_r);
                en_cnt += int'(latch_en);
            end
            if (done != 4'b0) begin
                if (dq.size() == 0) begin
                    check("done_unexpected", int'(done), 0);
                end else begin
                    e = dq.pop_front();
                    check("done_value", int'(done), int'(e.v));
                    check("done_cycle", cyc, e.cyc);
                    check("done_err", int'(err), int'(e.err));
                    check("s_high_cycles", s_cnt, e.op ? PW + 2 : 0);
                    check("r_high_cycles", r_cnt, e.op ? 0 : PW + 2);
                    check("en_high_cycles", en_cnt, PW);
                end
            end
            prev_gnt = gnt;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || gnt != 4'b0) && n < 40) begin
            @(negedge clk1);
            n++;
        end
        check("reach_idle", int'(busy), 0);
        @(negedge clk1);
    endtask

    task automatic push_txn(input logic [3:0] v, input logic o, input logic e, input int c0);
        gq.push_back('{v: v, op: o, err: 1'b0, cyc: c0});
        dq.push_back('{v: v, op: o, err: e, cyc: c0 + DLAT});
    endtask

    initial begin
        int         c;
        int         w;
        logic [3:0] v;
        logic [3:0] opv;
        int         n;
        exp_t       e;
        n_cmp    = 0;
        n_fail   = 0;
        force_q0 = 1'b0;
        rstn     = 1'b0;
        req      = 4'b1111;
        op       = 4'b0000;

        // Reset held with all requests pending.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk1);
            check("rst_gnt", int'(gnt), 0);
            check("rst_done", int'(done), 0);
            check("rst_s", int'(latch_s), 0);
            check("rst_r", int'(latch_r), 0);
            check("rst_en", int'(latch_en), 0);
            check("rst_err", int'(err), 0);
            check("rst_busy", int'(busy), 0);
        end
        rstn = 1'b1;
        c = cyc;
        push_txn(4'b0001, 1'b0, 1'b0, c + 1);
        @(negedge clk1);
        req = 4'b0000;
        wait_idle();

        // Single set on requester 2; request dropped right after grant.
        op  = 4'b0100;
        req = 4'b0100;
        c = cyc;
        push_txn(4'b0100, 1'b1, 1'b0, c + 1);
        @(negedge clk1);
        req = 4'b0000;
        wait_idle();
        check("q_after_set", int'(latch_q), 1);
        check("err_after_set", int'(err), 0);

        // Reset in the middle of the enable pulse.
        op  = 4'b0000;
        req = 4'b0100;
        c = cyc;
        gq.push_back('{v: 4'b0100, op: 1'b0, err: 1'b0, cyc: c + 1});
        repeat (2) @(negedge clk1);
        check("midrst_en_before", int'(latch_en), 1);
        rstn = 1'b0;
        req  = 4'b0000;
        @(negedge clk1);
        check("midrst_en", int'(latch_en), 0);
        check("midrst_gnt", int'(gnt), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_s", int'(latch_s), 0);
        check("midrst_done", int'(done), 0);
        @(negedge clk1);

        // Round robin with all requesters held; ptr restart means 0 goes first.
        rstn = 1'b1;
        req  = 4'b1111;
        opv  = 4'b0101;
        op   = opv;
        c = cyc;
        for (int k = 0; k < 5; k++) begin
            w = k % 4;
            v = 4'b0001 << w;
            push_txn(v, opv[w], 1'b0, c + 1 + k * PER);
        end
        repeat (4 * PER + 1) @(negedge clk1);
        req = 4'b0000;
        wait_idle();

        // Set with Q stuck low.
        force_q0 = 1'b1;
        op  = 4'b0010;
        req = 4'b0010;
        c = cyc;
        push_txn(4'b0010, 1'b1, ERR_MM, c + 1);
        @(negedge clk1);
        req = 4'b0000;
        wait_idle();
        repeat (3) @(negedge clk1);
        check("err_sticky", int'(err), int'(ERR_MM));
        rstn = 1'b0;
        @(negedge clk1);
        check("err_cleared_by_reset", int'(err), 0);
        rstn     = 1'b1;
        force_q0 = 1'b0;

        // Anything still queued was never presented by the DUT.
        n = 0;
        while ((gq.size() != 0 || dq.size() != 0) && n < 50) begin
            @(negedge clk1);
            n++;
        end
        while (gq.size() != 0) begin
            e = gq.pop_front();
            check("gnt_missing", 0, int'(e.v));
        end
        while (dq.size() != 0) begin
            e = dq.pop_front();
            check("done_missing", 0, int'(e.v));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
